// File: rtl/vga_text_console_if.sv
// Character stream and text-buffer port A bundle for the 80x30 text console.
// slave is the console side; master is the producer / buffer side.
interface vga_text_console_if #(
   parameter int ADDR_W = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_char;
   logic [7:0]        in_attr;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wd;
   logic [15:0]       mem_rd;

   modport slave (
      input  in_valid, in_char, in_attr, mem_rd,
      output in_ready, mem_en, mem_we, mem_addr, mem_wd
   );

   modport master (
      output in_valid, in_char, in_attr, mem_rd,
      input  in_ready, mem_en, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/vga_text_console.sv
// Character-stream front end for the text card: takes {attr,char} over
// valid/ready, keeps the cursor, handles CR/LF/BS, clears the screen and
// scrolls by copying cells through buffer port A.
// ROWS*COLS must not exceed 2**ADDR_W so cell addresses never wrap.
module vga_text_console #(
   parameter int         COLS       = 80,
   parameter int         ROWS       = 30,
   parameter logic [7:0] BLANK_ATTR = 8'h0F,
   parameter int         ADDR_W     = 12
) (
   input  logic               clk,
   input  logic               rst,
   vga_text_console_if.slave  bus,
   input  logic               clear,
   output logic               busy,
   output logic [4:0]         cursor_row,
   output logic [6:0]         cursor_col
);

   localparam int CELLS     = ROWS * COLS;
   localparam int CNT_W     = $clog2(CELLS + 1);
   localparam int COPY_LAST = (ROWS - 1) * COLS - 1;
   localparam int LAST_ROW0 = (ROWS - 1) * COLS;

   localparam logic [7:0]  CH_BS      = 8'h08;
   localparam logic [7:0]  CH_LF      = 8'h0A;
   localparam logic [7:0]  CH_CR      = 8'h0D;
   localparam logic [15:0] BLANK_CELL = {BLANK_ATTR, 8'h20};

   typedef enum logic [2:0] {CLR, IDLE, PROC, SC_RD, SC_WR, SC_BL} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [4:0]        row_q;
   logic [6:0]        col_q;
   logic [7:0]        char_q;
   logic [7:0]        attr_q;
   logic              pend_q;
   logic              busy_q;
   logic              en_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wd_q;
   logic              wd_from_rd_q;

   logic              accept;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [15:0]       acc_wd;
   logic              adv_row;
   logic              scroll_req;
   logic [4:0]        nxt_row;
   logic [6:0]        nxt_col;

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
      return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
   endfunction

   // A pending or fresh clear always beats an incoming character.
   assign bus.in_ready = (state == IDLE) && !clear && !pend_q;
   assign accept       = bus.in_valid && bus.in_ready;

   // During the copy phase the write data is the cell read in the previous cycle.
   assign bus.mem_wd   = wd_from_rd_q ? bus.mem_rd : wd_q;
   assign bus.mem_en   = en_q;
   assign bus.mem_we   = we_q;
   assign bus.mem_addr = addr_q;
   assign busy         = busy_q;
   assign cursor_row   = row_q;
   assign cursor_col   = col_q;

   // Write issued on the accept edge so it shows up in the very next cycle.
   always_comb begin
      acc_we   = 1'b0;
      acc_addr = cell_addr(row_q, col_q);
      acc_wd   = {bus.in_attr, bus.in_char};
      if (bus.in_char == CH_BS) begin
         if (col_q != 7'd0) begin
            acc_we   = 1'b1;
            acc_addr = cell_addr(row_q, col_q - 7'd1);
            acc_wd   = BLANK_CELL;
         end
      end else if (bus.in_char != CH_CR && bus.in_char != CH_LF) begin
         acc_we = 1'b1;
      end
   end

   // Cursor movement for the latched character, applied at the end of PROC.
   always_comb begin
      adv_row = 1'b0;
      nxt_col = col_q;
      case (char_q)
         CH_CR: nxt_col = 7'd0;
         CH_LF: begin
            nxt_col = 7'd0;
            adv_row = 1'b1;
         end
         CH_BS: if (col_q != 7'd0) nxt_col = col_q - 7'd1;
         default: begin
            if (col_q == 7'(COLS - 1)) begin
               nxt_col = 7'd0;
               adv_row = 1'b1;
            end else begin
               nxt_col = col_q + 7'd1;
            end
         end
      endcase
      scroll_req = adv_row && (row_q == 5'(ROWS - 1));
      nxt_row    = (adv_row && !scroll_req) ? row_q + 5'd1 : row_q;
   end

   // Latched character and attribute for the PROC cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         char_q <= bus.in_char;
         attr_q <= bus.in_attr;
      end
   end

   // Control FSM; port A outputs are registered for the cycle being entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= CLR;
         cnt          <= '0;
         row_q        <= '0;
         col_q        <= '0;
         pend_q       <= 1'b0;
         busy_q       <= 1'b0;
         en_q         <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wd_q         <= '0;
         wd_from_rd_q <= 1'b0;
      end else begin
         if (clear && state != IDLE) pend_q <= 1'b1;
         case (state)
            CLR: begin
               if (cnt == CNT_W'(CELLS)) begin
                  state  <= IDLE;
                  en_q   <= 1'b0;
                  we_q   <= 1'b0;
                  busy_q <= 1'b0;
                  row_q  <= '0;
                  col_q  <= '0;
               end else begin
                  en_q         <= 1'b1;
                  we_q         <= 1'b1;
                  addr_q       <= ADDR_W'(cnt);
                  wd_q         <= BLANK_CELL;
                  wd_from_rd_q <= 1'b0;
                  busy_q       <= 1'b1;
                  cnt          <= cnt + CNT_W'(1);
               end
            end
            IDLE: begin
               if (clear || pend_q) begin
                  state        <= CLR;
                  en_q         <= 1'b1;
                  we_q         <= 1'b1;
                  addr_q       <= '0;
                  wd_q         <= BLANK_CELL;
                  wd_from_rd_q <= 1'b0;
                  busy_q       <= 1'b1;
                  cnt          <= CNT_W'(1);
                  row_q        <= '0;
                  col_q        <= '0;
                  pend_q       <= 1'b0;
               end else if (accept) begin
                  state  <= PROC;
                  en_q   <= acc_we;
                  we_q   <= acc_we;
                  addr_q <= acc_addr;
                  wd_q   <= acc_wd;
               end
            end
            PROC: begin
               row_q <= nxt_row;
               col_q <= nxt_col;
               if (scroll_req) begin
                  state  <= SC_RD;
                  en_q   <= 1'b1;
                  we_q   <= 1'b0;
                  addr_q <= ADDR_W'(COLS);
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end else begin
                  state <= IDLE;
                  en_q  <= 1'b0;
                  we_q  <= 1'b0;
               end
            end
            SC_RD: begin
               state        <= SC_WR;
               we_q         <= 1'b1;
               addr_q       <= ADDR_W'(cnt);
               wd_from_rd_q <= 1'b1;
            end
            SC_WR: begin
               wd_from_rd_q <= 1'b0;
               if (cnt == CNT_W'(COPY_LAST)) begin
                  state  <= SC_BL;
                  cnt    <= CNT_W'(LAST_ROW0);
                  we_q   <= 1'b1;
                  addr_q <= ADDR_W'(LAST_ROW0);
                  wd_q   <= BLANK_CELL;
               end else begin
                  state  <= SC_RD;
                  we_q   <= 1'b0;
                  cnt    <= cnt + CNT_W'(1);
                  addr_q <= ADDR_W'(cnt) + ADDR_W'(COLS + 1);
               end
            end
            SC_BL: begin
               if (cnt == CNT_W'(CELLS - 1)) begin
                  state  <= IDLE;
                  en_q   <= 1'b0;
                  we_q   <= 1'b0;
                  busy_q <= 1'b0;
               end else begin
                  cnt    <= cnt + CNT_W'(1);
                  addr_q <= ADDR_W'(cnt + CNT_W'(1));
               end
            end
            default: state <= CLR;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: synchronous-read buffer model on port A and a
// screen/cursor reference model driven by the same character stream.
module tb_vga_text_console;

   localparam int COLS  = 80;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       busy;
   logic [4:0] cursor_row;
   logic [6:0] cursor_col;
   logic       preload_go = 1'b0;
   logic [15:0] ram [0:4095];
   logic [15:0] rd_q;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] ref_mem [0:CELLS-1];
   int ref_row = 0;
   int ref_col = 0;

   vga_text_console_if #(.ADDR_W(12)) bus ();

   vga_text_console #(
      .COLS(COLS), .ROWS(ROWS), .BLANK_ATTR(8'h0F), .ADDR_W(12)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .clear(clear),
      .busy(busy),
      .cursor_row(cursor_row),
      .cursor_col(cursor_col)
   );

   always #5 clk = ~clk;

   assign bus.mem_rd = rd_q;

   // Text buffer port A: synchronous read, one cycle latency.
   always @(posedge clk) begin
      if (preload_go) begin
         for (int k = 0; k < CELLS; k++) ram[k] <= 16'(k);
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wd;
         rd_q <= ram[bus.mem_addr];
      end
   end

   // ---------------- reference model ----------------
   task automatic ref_clear();
      for (int k = 0; k < CELLS; k++) ref_mem[k] = 16'h0F20;
      ref_row = 0;
      ref_col = 0;
   endtask

   task automatic ref_newline();
      if (ref_row == ROWS - 1) begin
         for (int k = 0; k < CELLS - COLS; k++) ref_mem[k] = ref_mem[k + COLS];
         for (int k = CELLS - COLS; k < CELLS; k++) ref_mem[k] = 16'h0F20;
      end else begin
         ref_row++;
      end
   endtask

   task automatic ref_put(input logic [7:0] ch, input logic [7:0] at,
                          output bit w, output int a, output logic [15:0] d);
      w = 1'b0; a = 0; d = 16'h0;
      if (ch == 8'h0D) begin
         ref_col = 0;
      end else if (ch == 8'h0A) begin
         ref_col = 0;
         ref_newline();
      end else if (ch == 8'h08) begin
         if (ref_col > 0) begin
            ref_col--;
            w = 1'b1; a = ref_row * COLS + ref_col; d = 16'h0F20;
            ref_mem[a] = d;
         end
      end else begin
         w = 1'b1; a = ref_row * COLS + ref_col; d = {at, ch};
         ref_mem[a] = d;
         ref_col++;
         if (ref_col == COLS) begin
            ref_col = 0;
            ref_newline();
         end
      end
   endtask

   function automatic int ram_diffs();
      int n = 0;
      for (int k = 0; k < CELLS; k++) if (ram[k] !== ref_mem[k]) n++;
      return n;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic wait_ready();
      int t = 0;
      while (bus.in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (bus.in_ready !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL ready_timeout: in_ready=%b, required 1", bus.in_ready);
      end
   endtask

   // Send one character; returns what port A showed in the cycle after the
   // handshake, and waits out any scroll it caused.
   task automatic send_char(input logic [7:0] ch, input logic [7:0] at,
                            output bit w, output int a, output logic [15:0] d,
                            output bit rdy_low);
      int t;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_char  = ch;
      bus.in_attr  = at;
      @(negedge clk);
      bus.in_valid = 1'b0;
      w       = (bus.mem_en === 1'b1) && (bus.mem_we === 1'b1);
      a       = int'(bus.mem_addr);
      d       = bus.mem_wd;
      rdy_low = (bus.in_ready === 1'b0);
      @(negedge clk);
      t = 0;
      while (busy === 1'b1 && t < 6000) begin
         @(negedge clk);
         t++;
      end
   endtask

   // Observe one clear sequence: busy cycle count and number of bad cells.
   task automatic measure_clear(output int busy_cycles, output int bad);
      int  cnts [CELLS];
      bit  seen;
      busy_cycles = 0; bad = 0; seen = 1'b0;
      for (int k = 0; k < CELLS; k++) cnts[k] = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         clear        = 1'b0;
         bus.in_valid = 1'b0;
         if (busy === 1'b1) begin
            busy_cycles++;
            seen = 1'b1;
            if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
               if (int'(bus.mem_addr) < CELLS && bus.mem_wd === 16'h0F20)
                  cnts[int'(bus.mem_addr)]++;
               else
                  bad++;
            end
         end else if (seen) begin
            break;
         end
      end
      for (int k = 0; k < CELLS; k++) if (cnts[k] != 1) bad++;
   endtask

   task automatic start_lf();
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_char  = 8'h0A;
      bus.in_attr  = 8'h00;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int bc, bad;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'd0 || bus.mem_wd !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mem: en=%b we=%b addr=%0d wd=%h, required all 0", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wd);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: in_ready=%b busy=%b cursor=(%0d,%0d), required 0 0 (0,0)", bus.in_ready, busy, cursor_row, cursor_col);
      end
      rst = 1'b1;
      measure_clear(bc, bad);
      ref_clear();
      n_checks++;
      if (bc !== 2400) begin
         n_fail++; $display("FAIL reset_clear_len: busy cycles=%0d, required 2400", bc);
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL reset_clear_cells: bad cells=%0d, required 0", bad);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_idle: in_ready=%b cursor=(%0d,%0d), required 1 (0,0)", bus.in_ready, cursor_row, cursor_col);
      end
   endtask

   task automatic test_single_char();
      bit w, mw, rl; int a, ma; logic [15:0] d, md;
      send_char(8'h41, 8'h1E, w, a, d, rl);
      ref_put(8'h41, 8'h1E, mw, ma, md);
      n_checks++;
      if (w !== 1'b1 || a !== 0 || d !== 16'h1E41) begin
         n_fail++; $display("FAIL char_A_write: we=%b addr=%0d wd=%h, required 1 0 1e41", w, a, d);
      end
      n_checks++;
      if (rl !== 1'b1 || bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
         n_fail++; $display("FAIL char_A_ready: low_after_accept=%b ready_now=%b we_now=%b, required 1 1 0", rl, bus.in_ready, bus.mem_we);
      end
      n_checks++;
      if (cursor_row !== 5'd0 || cursor_col !== 7'd1) begin
         n_fail++; $display("FAIL char_A_cursor: (%0d,%0d), required (0,1)", cursor_row, cursor_col);
      end
   endtask

   task automatic test_line_wrap();
      bit w, mw, rl; int a, ma, bad; logic [15:0] d, md; logic [7:0] ch, at;
      send_char(8'h0D, 8'h00, w, a, d, rl);
      ref_put(8'h0D, 8'h00, mw, ma, md);
      bad = 0;
      for (int k = 0; k < COLS; k++) begin
         ch = 8'($urandom_range(33, 126));
         at = 8'($urandom_range(0, 255));
         send_char(ch, at, w, a, d, rl);
         ref_put(ch, at, mw, ma, md);
         if (w !== 1'b1 || a !== k || d !== md) bad++;
      end
      n_checks++;
      if (bad !== 0 || a !== 79) begin
         n_fail++; $display("FAIL wrap_writes: bad=%0d last_addr=%0d, required 0 79", bad, a);
      end
      n_checks++;
      if (cursor_row !== 5'd1 || cursor_col !== 7'd0) begin
         n_fail++; $display("FAIL wrap_cursor: (%0d,%0d), required (1,0)", cursor_row, cursor_col);
      end
      send_char(8'h08, 8'h00, w, a, d, rl);
      ref_put(8'h08, 8'h00, mw, ma, md);
      n_checks++;
      if (w !== 1'b0 || cursor_row !== 5'd1 || cursor_col !== 7'd0) begin
         n_fail++; $display("FAIL bs_col0: we=%b cursor=(%0d,%0d), required 0 (1,0)", w, cursor_row, cursor_col);
      end
      send_char(8'h42, 8'h2A, w, a, d, rl);
      ref_put(8'h42, 8'h2A, mw, ma, md);
      send_char(8'h08, 8'h00, w, a, d, rl);
      ref_put(8'h08, 8'h00, mw, ma, md);
      n_checks++;
      if (w !== 1'b1 || a !== 80 || d !== 16'h0F20 || cursor_row !== 5'd1 || cursor_col !== 7'd0) begin
         n_fail++; $display("FAIL bs_blank: we=%b addr=%0d wd=%h cursor=(%0d,%0d), required 1 80 0f20 (1,0)", w, a, d, cursor_row, cursor_col);
      end
   endtask

   task automatic test_random_stream();
      bit w, mw, rl; int a, ma, bad_w, bad_c; logic [15:0] d, md; logic [7:0] ch, at;
      int r;
      bad_w = 0; bad_c = 0;
      for (int k = 0; k < 120; k++) begin
         r  = int'($urandom_range(0, 11));
         ch = (r == 0) ? 8'h0A : (r == 1) ? 8'h0D : (r <= 3) ? 8'h08 : 8'($urandom_range(32, 126));
         at = 8'($urandom_range(0, 255));
         send_char(ch, at, w, a, d, rl);
         ref_put(ch, at, mw, ma, md);
         if (w !== mw || (mw && (a !== ma || d !== md))) begin
            bad_w++;
            if (bad_w < 4) $display("FAIL rand_write: ch=%h we=%b addr=%0d wd=%h, required we=%b addr=%0d wd=%h", ch, w, a, d, mw, ma, md);
         end
         if (cursor_row !== 5'(ref_row) || cursor_col !== 7'(ref_col)) bad_c++;
      end
      n_checks++;
      if (bad_w !== 0) n_fail++;
      n_checks++;
      if (bad_c !== 0) begin
         n_fail++; $display("FAIL rand_cursor: %0d wrong cursors, required 0", bad_c);
      end
      n_checks++;
      if (ram_diffs() !== 0) begin
         n_fail++; $display("FAIL rand_screen: %0d cells differ, required 0", ram_diffs());
      end
   endtask

   task automatic test_scroll();
      bit w, mw, rl; int a, ma, bc, blank_bad; logic [15:0] d, md;
      send_char(8'h0D, 8'h00, w, a, d, rl);
      ref_put(8'h0D, 8'h00, mw, ma, md);
      while (ref_row < ROWS - 1) begin
         send_char(8'h0A, 8'h00, w, a, d, rl);
         ref_put(8'h0A, 8'h00, mw, ma, md);
      end
      for (int k = 0; k < 5; k++) begin
         send_char(8'h78, 8'h07, w, a, d, rl);
         ref_put(8'h78, 8'h07, mw, ma, md);
      end
      preload_go = 1'b1;
      @(negedge clk);
      preload_go = 1'b0;
      for (int k = 0; k < CELLS; k++) ref_mem[k] = 16'(k);
      start_lf();
      bc = 0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         if (busy === 1'b1) bc++;
         else if (bc > 0) break;
      end
      ref_put(8'h0A, 8'h00, mw, ma, md);
      n_checks++;
      if (bc !== 4720) begin
         n_fail++; $display("FAIL scroll_len: busy cycles=%0d, required 4720", bc);
      end
      n_checks++;
      if (cursor_row !== 5'd29 || cursor_col !== 7'd0) begin
         n_fail++; $display("FAIL scroll_cursor: (%0d,%0d), required (29,0)", cursor_row, cursor_col);
      end
      n_checks++;
      if (ram[0] !== 16'd80 || ram[2319] !== 16'd2399) begin
         n_fail++; $display("FAIL scroll_copy: cell0=%0d cell2319=%0d, required 80 2399", ram[0], ram[2319]);
      end
      blank_bad = 0;
      for (int k = CELLS - COLS; k < CELLS; k++) if (ram[k] !== 16'h0F20) blank_bad++;
      n_checks++;
      if (blank_bad !== 0) begin
         n_fail++; $display("FAIL scroll_blank_row: %0d cells not 0f20, required 0", blank_bad);
      end
      n_checks++;
      if (ram_diffs() !== 0) begin
         n_fail++; $display("FAIL scroll_screen: %0d cells differ, required 0", ram_diffs());
      end
   endtask

   task automatic test_clear_pending();
      int runs[$]; int cur; bit mw; int ma; logic [15:0] md;
      cur = 0;
      start_lf();
      for (int c = 0; c < 7300; c++) begin
         @(negedge clk);
         if (busy === 1'b1) cur++;
         else if (cur > 0) begin
            runs.push_back(cur);
            cur = 0;
         end
         clear = (runs.size() == 0 && cur == 100);
      end
      clear = 1'b0;
      if (cur > 0) runs.push_back(cur);
      ref_put(8'h0A, 8'h00, mw, ma, md);
      ref_clear();
      n_checks++;
      if (runs.size() != 2 || runs[0] !== 4720 || runs[1] !== 2400) begin
         n_fail++;
         $display("FAIL pend_runs: %0d busy runs (first=%0d second=%0d), required 2 runs 4720 2400",
                  runs.size(), (runs.size() > 0) ? runs[0] : 0, (runs.size() > 1) ? runs[1] : 0);
      end
      n_checks++;
      if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || ram_diffs() !== 0) begin
         n_fail++; $display("FAIL pend_result: cursor=(%0d,%0d) diffs=%0d, required (0,0) 0", cursor_row, cursor_col, ram_diffs());
      end
   endtask

   task automatic test_clear_with_valid();
      bit w, mw, rl; int a, ma, bc, bad; logic [15:0] d, md; logic [7:0] ch;
      for (int k = 0; k < 3; k++) begin
         ch = 8'($urandom_range(33, 126));
         send_char(ch, 8'h3C, w, a, d, rl);
         ref_put(ch, 8'h3C, mw, ma, md);
      end
      wait_ready();
      clear        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_char  = 8'h5A;
      bus.in_attr  = 8'h55;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL clr_valid_ready: in_ready=%b, required 0", bus.in_ready);
      end
      measure_clear(bc, bad);
      ref_clear();
      n_checks++;
      if (bc !== 2400 || bad !== 0) begin
         n_fail++; $display("FAIL clr_valid_clear: busy=%0d bad=%0d, required 2400 0", bc, bad);
      end
      n_checks++;
      if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || bus.in_ready !== 1'b1 || ram_diffs() !== 0) begin
         n_fail++; $display("FAIL clr_valid_result: cursor=(%0d,%0d) ready=%b diffs=%0d, required (0,0) 1 0",
                            cursor_row, cursor_col, bus.in_ready, ram_diffs());
      end
   endtask

   task automatic test_reset_mid_scroll();
      bit w, mw, rl; int a, ma, bc, bad, cnt; logic [15:0] d, md;
      for (int k = 0; k < ROWS - 1; k++) begin
         send_char(8'h0A, 8'h00, w, a, d, rl);
         ref_put(8'h0A, 8'h00, mw, ma, md);
      end
      start_lf();
      cnt = 0;
      for (int c = 0; c < 2000 && cnt < 1000; c++) begin
         @(negedge clk);
         if (busy === 1'b1) cnt++;
      end
      n_checks++;
      if (bus.mem_we !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_we: mem_we=%b at scroll cycle %0d, required 1", bus.mem_we, cnt);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_we !== 1'b0 || bus.mem_en !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_async: we=%b en=%b busy=%b ready=%b, required 0 0 0 0", bus.mem_we, bus.mem_en, busy, bus.in_ready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      measure_clear(bc, bad);
      ref_clear();
      n_checks++;
      if (bc !== 2400 || bad !== 0) begin
         n_fail++; $display("FAIL rst_reclear: busy=%0d bad=%0d, required 2400 0", bc, bad);
      end
      n_checks++;
      if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || ram_diffs() !== 0) begin
         n_fail++; $display("FAIL rst_result: cursor=(%0d,%0d) diffs=%0d, required (0,0) 0", cursor_row, cursor_col, ram_diffs());
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_char  = 8'h00;
      bus.in_attr  = 8'h00;
      test_reset();
      test_single_char();
      test_line_wrap();
      test_random_stream();
      test_scroll();
      test_clear_pending();
      test_clear_with_valid();
      test_reset_mid_scroll();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
